alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Parametrised RV32IM execute stage: decodes ALUOp/funct3/funct7 into an internal ALU code
//   and produces the result. Base I/R ops take one cycle; M-extension ops run on an
//   iterative 1-bit/cycle multiplier/divider.
//   Sits between the register-read stage and writeback, with valid/ready handshakes on both
//   sides so the core can stall on multi-cycle ops.
// PARAMETERS
//   XLEN   32  operand/result width; power of two, >= 8
//   EN_M   1   1 = implement MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = flag them illegal
// PORTS
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous, active-high reset
//   in_valid   in   1     operation presented
//   in_ready   out  1     unit can accept; transfer when in_valid & in_ready
//   alu_op     in   2     00 ADD (ld/st/addr), 01 SUB (branch), 10 R-type, 11 I-type ALU
//   funct3     in   3     instruction funct3
//   funct7     in   7     instruction funct7 (I-type: only bit 5 used, and only for SRAI)
//   op_a       in   XLEN  rs1 value
//   op_b       in   XLEN  rs2 value or sign-extended immediate
//   out_valid  out  1     result available
//   out_ready  in   1     consumer accepts; transfer when out_valid & out_ready
//   result     out  XLEN  operation result, held stable while out_valid & !out_ready
//   illegal    out  1     qualifies result: undefined encoding, or M-op with EN_M=0
//   busy       out  1     high in CALC state
// BEHAVIOUR
//   - Reset: state=IDLE; out_valid=0, result=0, illegal=0, busy=0; in_ready=1 the cycle after.
//   - FSM IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, M-op) -> CALC;
//     CALC -> (count==XLEN-1) -> DONE; DONE -> (out_ready) -> IDLE, or CALC/DONE directly on
//     a same-cycle accept.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back issue, no bubble.
//   - Latency (accept edge to out_valid): 1 cycle for base ops; XLEN+1 cycles for M-ops.
//   - Operands and decoded code are captured on accept; inputs are don't-care afterwards.
//   - Decode: alu_op 10 & funct7=0100000 selects SUB (f3=000) / SRA (f3=101); funct7=0000001
//     selects M-ops; other funct7 values with alu_op=10 -> illegal=1, result=0.
//     alu_op 11 ignores funct7 except SRAI/SRLI (f3=101, bit5).
//   - Shift amount = op_b[$clog2(XLEN)-1:0]. SLT/SLTU results are zero-extended 1-bit.
//   - MUL family: magnitudes multiplied by shift-add over XLEN cycles into a 2*XLEN
//     accumulator, sign fixed on DONE entry. MUL = low XLEN; MULH/MULHSU/MULHU = high XLEN
//     with s*s, s*u, u*u signedness.
//   - DIV family: restoring, XLEN cycles on magnitudes, sign fixup on exit.
//     Quotient sign = sa^sb; remainder sign = sign of dividend.
//   - Divide by zero: DIV/DIVU = all ones; REM/REMU = op_a. Still XLEN+1 latency.
//   - Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV = op_a, REM = 0.
//   - rst during CALC/DONE: operation discarded, outputs return to reset values next cycle.
//   - out_valid never drops without out_ready; result/illegal are unchanged while stalled.
// STRUCTURE
//   - alu_pkg: alu_op encodings (ALUOP_ADD/SUB/RTYPE/ITYPE), internal alu_code_e enum
//     (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU),
//     FSM state enum.
//   - Sub-module alu_op_decode: pure combinational (alu_op,funct3,funct7,EN_M) ->
//     (alu_code, is_multi, illegal).
//   - Top: single-cycle datapath, iterative MDU datapath, FSM and iteration counter.
// TESTING
//   1 ADD: alu_op=00, a=5, b=-3 -> out_valid next cycle, result=2, illegal=0.
//   2 R SRA vs SRL: f3=101, a=0x80000010, b=4; f7=0100000 -> 0xF8000001;
//     f7=0 -> 0x08000001.
//   3 MULH: a=0x80000000, b=0x80000000 -> result 0x40000000 exactly 33 cycles after accept;
//     busy high 32 cycles; MULHU with the same operands -> 0x40000000; MUL -> 0.
//   4 DIV corners: a=7,b=0 -> DIV 0xFFFFFFFF, REM 7; a=0x80000000,b=-1 -> DIV 0x80000000,
//     REM 0; a=-7,b=2 -> DIV -3, REM -1.
//   5 Backpressure: hold out_ready=0 for 5 cycles after SLT(-1,1) -> result=1 held stable,
//     in_ready=0; release with a new in_valid -> next op accepted same cycle, no bubble.
//   6 rst mid-DIVU at iteration 10 -> next cycle out_valid=0, busy=0, in_ready=1;
//     EN_M=0 build: MUL -> illegal=1, result=0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the RV32IM execute stage.
//   - ALUOP_* : alu_op field values from the main decoder
//   - F7_*    : funct7 patterns that select base/alternate/M-extension ops
//   - alu_code_e : internal ALU operation code
//   - state_e    : execute FSM state
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Base integer op from funct3; alt selects the arithmetic right shift.
  function automatic alu_code_e base_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_code = ALU_ADD;
      3'b001:  base_code = ALU_SLL;
      3'b010:  base_code = ALU_SLT;
      3'b011:  base_code = ALU_SLTU;
      3'b100:  base_code = ALU_XOR;
      3'b101:  base_code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_code = ALU_OR;
      default: base_code = ALU_AND;
    endcase
  endfunction

  function automatic alu_code_e md_code(input logic [2:0] f3);
    case (f3)
      3'b000:  md_code = ALU_MUL;
      3'b001:  md_code = ALU_MULH;
      3'b010:  md_code = ALU_MULHSU;
      3'b011:  md_code = ALU_MULHU;
      3'b100:  md_code = ALU_DIV;
      3'b101:  md_code = ALU_DIVU;
      3'b110:  md_code = ALU_REM;
      default: md_code = ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational decode of (alu_op, funct3, funct7) into the
// internal ALU code.
//   alu_op   in  2   operation class from the main decoder
//   funct3   in  3   instruction funct3
//   funct7   in  7   instruction funct7
//   alu_code out     internal operation code
//   is_multi out 1   operation runs on the iterative mul/div datapath
//   illegal  out 1   encoding not supported by this build
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_code_e  alu_code,
  output logic       is_multi,
  output logic       illegal
);

  always_comb begin
    alu_code = ALU_ADD;
    is_multi = 1'b0;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          alu_code = base_code(funct3, 1'b0);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      alu_code = ALU_SUB;
          else if (funct3 == 3'b101) alu_code = ALU_SRA;
          else                       illegal  = 1'b1;
        end else if (funct7 == F7_MULDIV && EN_M) begin
          alu_code = md_code(funct3);
          is_multi = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      // Immediates: funct7 only matters for SRAI vs SRLI.
      ALUOP_ITYPE: alu_code = base_code(funct3, funct7[5]);
      default:     illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32IM execute stage with valid/ready on both sides.
// Base ops finish in one cycle; M-ops use a 1-bit/cycle shift-add multiplier
// or restoring divider on operand magnitudes, with sign fixup on completion.
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             issue handshake
//   alu_op, funct3, funct7        operation encoding
//   op_a, op_b                    rs1 and rs2/immediate
//   out_valid/out_ready           result handshake
//   result, illegal               result and its illegal-encoding flag
//   busy                          iterative op in progress
//
// state   | meaning
// IDLE    | no operation held, ready to accept
// CALC    | iterating mul/div, one bit per cycle
// DONE    | result valid, waiting for out_ready
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  alu_code_e w_code;
  logic      w_multi, w_illegal;

  alu_op_decode #(.EN_M(EN_M)) u_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_code (w_code),
    .is_multi (w_multi),
    .illegal  (w_illegal)
  );

  state_e            r_state;
  alu_code_e         r_code;
  logic              r_out_valid, r_busy, r_illegal;
  logic              r_is_div, r_neg, r_neg_r, r_bzero;
  logic [XLEN-1:0]   r_result, r_m;
  logic [2*XLEN-1:0] r_acc;
  logic [SHW-1:0]    r_cnt;

  logic w_accept;
  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign busy      = r_busy;

  // Single-cycle datapath
  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_alu;
  assign w_sh = op_b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (w_code)
      ALU_ADD:  w_alu = op_a + op_b;
      ALU_SUB:  w_alu = op_a - op_b;
      ALU_SLL:  w_alu = op_a << w_sh;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  w_alu = op_a ^ op_b;
      ALU_SRL:  w_alu = op_a >> w_sh;
      ALU_SRA:  w_alu = $unsigned($signed(op_a) >>> w_sh);
      ALU_OR:   w_alu = op_a | op_b;
      ALU_AND:  w_alu = op_a & op_b;
      default:  w_alu = '0;
    endcase
  end

  // Operand signedness and magnitudes for the iterative datapath
  logic            w_a_sgn, w_b_sgn, w_div_op, w_sa, w_sb;
  logic [XLEN-1:0] w_ma, w_mb;
  assign w_a_sgn  = w_code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign w_b_sgn  = w_code inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign w_div_op = w_code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign w_sa     = w_a_sgn & op_a[XLEN-1];
  assign w_sb     = w_b_sgn & op_b[XLEN-1];
  assign w_ma     = w_sa ? -op_a : op_a;
  assign w_mb     = w_sb ? -op_b : op_b;

  // Multiply step: r_acc = {partial high, remaining multiplier bits}
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  // Divide step: r_acc = {partial remainder, dividend bits shifting into quotient}.
  // The remainder stays below the divisor, so its low XLEN bits are exact.
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ok;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_next;
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ok    = w_div_shift >= {1'b0, r_m};
  assign w_div_rem   = w_div_shift[XLEN-1:0] - (w_div_ok ? r_m : '0);
  assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ok};

  // Completion value, taken from the final iteration's next-state
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_mdu_res;
  assign w_prod = r_neg   ? -w_mul_next : w_mul_next;
  assign w_quo  = r_neg   ? -w_div_next[XLEN-1:0] : w_div_next[XLEN-1:0];
  // A zero divisor leaves the dividend magnitude in the remainder, so REM
  // naturally returns op_a; only the quotient needs forcing.
  assign w_rem  = r_neg_r ? -w_div_next[2*XLEN-1:XLEN] : w_div_next[2*XLEN-1:XLEN];

  always_comb begin
    w_mdu_res = '0;
    case (r_code)
      ALU_MUL:                        w_mdu_res = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: w_mdu_res = w_prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              w_mdu_res = r_bzero ? '1 : w_quo;
      default:                        w_mdu_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_code      <= ALU_ADD;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_illegal   <= 1'b0;
      r_result    <= '0;
      r_is_div    <= 1'b0;
      r_neg       <= 1'b0;
      r_neg_r     <= 1'b0;
      r_bzero     <= 1'b0;
      r_m         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_code <= w_code;
      if (w_multi) begin
        r_state     <= ST_CALC;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
        r_cnt       <= '0;
        r_is_div    <= w_div_op;
        r_neg       <= w_sa ^ w_sb;
        r_neg_r     <= w_sa;
        r_bzero     <= (op_b == '0);
        r_m         <= w_div_op ? w_mb : w_ma;
        r_acc       <= {{XLEN{1'b0}}, w_div_op ? w_ma : w_mb};
      end else begin
        r_state     <= ST_DONE;
        r_out_valid <= 1'b1;
        r_illegal   <= w_illegal;
        r_result    <= w_illegal ? '0 : w_alu;
      end
    end else if (r_state == ST_DONE && out_ready) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else if (r_state == ST_CALC) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == SHW'(XLEN-1)) begin
        r_state     <= ST_DONE;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b1;
        r_illegal   <= 1'b0;
        r_result    <= w_mdu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a, op_b, result;

  logic            m0_in_valid, m0_in_ready, m0_out_valid, m0_out_ready, m0_illegal, m0_busy;
  logic [1:0]      m0_alu_op;
  logic [2:0]      m0_funct3;
  logic [6:0]      m0_funct7;
  logic [XLEN-1:0] m0_op_a, m0_op_b, m0_result;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .EN_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal), .busy(busy)
  );

  alu_exec_unit #(.XLEN(XLEN), .EN_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
    .alu_op(m0_alu_op), .funct3(m0_funct3), .funct7(m0_funct7), .op_a(m0_op_a),
    .op_b(m0_op_b), .out_valid(m0_out_valid), .out_ready(m0_out_ready),
    .result(m0_result), .illegal(m0_illegal), .busy(m0_busy)
  );

  typedef struct {
    string           name;
    logic [XLEN-1:0] res;
    logic            ill;
  } sb_t;

  sb_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every result transfer pops the oldest expectation
  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_illegal"}, illegal, e.ill);
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] er, input logic ei);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{name: name, res: er, ill: ei});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk({name, "_accept"}, in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] er, input logic ei, input int elat, input int ebusy);
    int lat, nb;
    issue(name, op, f3, f7, a, b, er, ei);
    wait_out(lat, nb);
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busy_cycles"}, nb, ebusy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    m0_in_valid = 1'b0; m0_out_ready = 1'b1;
    m0_alu_op = '0; m0_funct3 = '0; m0_funct7 = '0; m0_op_a = '0; m0_op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Base ops
    run("add",     2'b00, 3'b000, 7'h00, 32'd5,        32'hFFFFFFFD, 32'd2,        0, 1, 0);
    run("sra",     2'b10, 3'b101, 7'h20, 32'h80000010, 32'd4,        32'hF8000001, 0, 1, 0);
    run("srl",     2'b10, 3'b101, 7'h00, 32'h80000010, 32'd4,        32'h08000001, 0, 1, 0);
    run("br_sub",  2'b01, 3'b000, 7'h00, 32'd10,       32'd3,        32'd7,        0, 1, 0);
    run("r_sub",   2'b10, 3'b000, 7'h20, 32'd3,        32'd10,       32'hFFFFFFF9, 0, 1, 0);
    run("sltu",    2'b10, 3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1,        0, 1, 0);
    run("slti",    2'b11, 3'b010, 7'h7F, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        0, 1, 0);
    run("srai",    2'b11, 3'b101, 7'h20, 32'h80000000, 32'd31,       32'hFFFFFFFF, 0, 1, 0);
    run("slli",    2'b11, 3'b001, 7'h00, 32'd1,        32'h00000024, 32'd16,       0, 1, 0);
    run("xori",    2'b11, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 0, 1, 0);
    run("and",     2'b10, 3'b111, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 1, 0);
    run("or",      2'b10, 3'b110, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 1, 0);
    run("bad_f7",  2'b10, 3'b000, 7'h02, 32'd5,        32'd6,        32'd0,        1, 1, 0);
    run("bad_alt", 2'b10, 3'b001, 7'h20, 32'd5,        32'd6,        32'd0,        1, 1, 0);

    // M extension
    run("mulh",    2'b10, 3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 0, 33, 32);
    run("mulhu",   2'b10, 3'b011, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 0, 33, 32);
    run("mul_0",   2'b10, 3'b000, 7'h01, 32'h80000000, 32'h80000000, 32'd0,        0, 33, 32);
    run("mul_neg", 2'b10, 3'b000, 7'h01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33, 32);
    run("mulhsu",  2'b10, 3'b010, 7'h01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 33, 32);
    run("div_z",   2'b10, 3'b100, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 33, 32);
    run("rem_z",   2'b10, 3'b110, 7'h01, 32'd7,        32'd0,        32'd7,        0, 33, 32);
    run("divn_z",  2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 0, 33, 32);
    run("remn_z",  2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0, 33, 32);
    run("divu_z",  2'b10, 3'b101, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 33, 32);
    run("remu_z",  2'b10, 3'b111, 7'h01, 32'd7,        32'd0,        32'd7,        0, 33, 32);
    run("div_ovf", 2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 33, 32);
    run("rem_ovf", 2'b10, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 33, 32);
    run("div_neg", 2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33, 32);
    run("rem_neg", 2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33, 32);
    run("divu",    2'b10, 3'b101, 7'h01, 32'd100,      32'd7,        32'd14,       0, 33, 32);
    run("remu",    2'b10, 3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        0, 33, 32);

    // Backpressure then back-to-back issue
    begin
      int lat, nb;
      out_ready = 1'b0;
      issue("slt_bp", 2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_result", result, 1);
        chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", in_ready, 1);
      issue("add_b2b", 2'b00, 3'b000, 7'h00, 32'd1, 32'd1, 32'd2, 0);
      wait_out(lat, nb);
      chk("add_b2b_latency", lat, 1);
    end

    // Reset in the middle of a divide
    issue("divu_rst", 2'b10, 3'b101, 7'h01, 32'd100, 32'd7, 32'd14, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_busy_before", busy, 1);
    chk("rst_mid_in_ready_before", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_result", result, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_late_out", out_valid, 0);

    // Build without M extension
    m0_alu_op = 2'b10; m0_funct3 = 3'b000; m0_funct7 = 7'h01;
    m0_op_a = 32'd3; m0_op_b = 32'd4; m0_in_valid = 1'b1;
    @(negedge clk);
    chk("nom_in_ready", m0_in_ready, 1);
    @(posedge clk);
    #1;
    m0_in_valid = 1'b0;
    @(negedge clk);
    chk("nom_mul_out_valid", m0_out_valid, 1);
    chk("nom_mul_illegal", m0_illegal, 1);
    chk("nom_mul_result", m0_result, 0);
    chk("nom_mul_busy", m0_busy, 0);
    @(posedge clk);
    #1;
    m0_alu_op = 2'b00; m0_funct3 = 3'b000; m0_funct7 = 7'h00; m0_in_valid = 1'b1;
    @(posedge clk);
    #1;
    m0_in_valid = 1'b0;
    @(negedge clk);
    chk("nom_add_result", m0_result, 7);
    chk("nom_add_illegal", m0_illegal, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
